// File: rtl/div3_scheduler.sv
// Two-requester front end for a shared bit-serial mod-3 engine: round-robin grant,
// MSB-first shift, one-cycle result strobe carrying remainder, div3 flag and requester id.
module div3_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_div3,
    output logic [1:0]       res_rem,
    output logic             res_id,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count;
    logic [1:0]       remainder;
    logic [1:0]       rem_next;
    logic             id;
    logic             last_id;
    logic             grant;
    logic             take;
    logic             bit_in;

    // A lone requester always wins; on a tie the one not served last goes next.
    always_comb begin
        grant = ~last_id;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign take       = req0_ready || req1_ready;
    assign busy       = (state != IDLE);
    assign bit_in     = shift_reg[WIDTH-1];

    // Next remainder = (2*remainder + bit) mod 3.
    always_comb begin
        rem_next = 2'd0;
        case ({remainder, bit_in})
            3'b000:  rem_next = 2'd0;
            3'b001:  rem_next = 2'd1;
            3'b010:  rem_next = 2'd2;
            3'b011:  rem_next = 2'd0;
            3'b100:  rem_next = 2'd1;
            3'b101:  rem_next = 2'd2;
            default: rem_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            remainder <= 2'd0;
            id        <= 1'b0;
            last_id   <= 1'b1;
            res_valid <= 1'b0;
            res_div3  <= 1'b0;
            res_rem   <= 2'd0;
            res_id    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        shift_reg <= grant ? req1_data : req0_data;
                        id        <= grant;
                        last_id   <= grant;
                        remainder <= 2'd0;
                        count     <= CW'(WIDTH);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    remainder <= rem_next;
                    shift_reg <= shift_reg << 1;
                    count     <= count - CW'(1);
                    // Result registers load on the final bit so they are valid during DONE.
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_rem   <= rem_next;
                        res_div3  <= (rem_next == 2'd0);
                        res_id    <= id;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div3_scheduler.sv
// Directed bench for div3_scheduler: drivers push expected results on each handshake,
// a monitor pops and compares on every res_valid strobe.
module tb_div3_scheduler;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [WIDTH-1:0] req1_data = '0;
  logic             req1_ready;
  logic             res_valid;
  logic             res_div3;
  logic [1:0]       res_rem;
  logic             res_id;
  logic             busy;

  div3_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_div3(res_div3), .res_rem(res_rem),
    .res_id(res_id), .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // scoreboard: {id, div3, rem}, plus handshake cycle for latency
  logic [3:0] exp_q[$];
  int         hs_q[$];
  int         hs_log_cyc[$];
  bit         hs_log_id[$];
  logic [3:0] e;
  int         h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready || req1_ready) check("ready_while_busy", {31'd0, busy}, 32'd0);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          h = hs_q.pop_front();
          check("res_rem", {30'd0, res_rem}, {30'd0, e[1:0]});
          check("res_div3", {31'd0, res_div3}, {31'd0, e[2]});
          check("res_id", {31'd0, res_id}, {31'd0, e[3]});
          check("latency", cyc - h, WIDTH + 1);
          check("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_hs(input bit id, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 200);
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input bit id, input logic [WIDTH-1:0] d, input logic [1:0] rem);
    bit ok;
    if (id) begin req1_data = d; req1_valid = 1'b1; end
    else    begin req0_data = d; req0_valid = 1'b1; end
    wait_hs(id, ok);
    if (ok) begin
      exp_q.push_back({id, rem == 2'd0, rem});
      hs_q.push_back(cyc);
      hs_log_cyc.push_back(cyc);
      hs_log_id.push_back(id);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_res_div3"}, {31'd0, res_div3}, 32'd0);
    check({tag, "_res_rem"}, {30'd0, res_rem}, 32'd0);
    check({tag, "_res_id"}, {31'd0, res_id}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // single request: 0x93 = 147 -> rem 0
    send(1'b0, 8'h93, 2'd0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    drain();

    // remainder coverage via req1
    send(1'b1, 8'h19, 2'd1); drain();
    send(1'b1, 8'h05, 2'd2); drain();
    send(1'b1, 8'hFF, 2'd0); drain();
    send(1'b1, 8'h00, 2'd0); drain();

    // arbitration from reset, both valid continuously
    rst = 1'b1; repeat (2) @(posedge clk); #1 rst = 1'b0;
    hs_log_cyc.delete(); hs_log_id.delete();
    fork
      begin send(1'b0, 8'h03, 2'd0); send(1'b0, 8'h03, 2'd0); end
      begin send(1'b1, 8'h04, 2'd1); send(1'b1, 8'h04, 2'd1); end
    join
    drain();
    check("arb_count", hs_log_id.size(), 32'd4);
    if (hs_log_id.size() == 4) begin
      check("arb_grant0", {31'd0, hs_log_id[0]}, 32'd0);
      check("arb_grant1", {31'd0, hs_log_id[1]}, 32'd1);
      check("arb_grant2", {31'd0, hs_log_id[2]}, 32'd0);
      check("arb_grant3", {31'd0, hs_log_id[3]}, 32'd1);
    end

    // back-to-back on req0
    hs_log_cyc.delete(); hs_log_id.delete();
    send(1'b0, 8'h93, 2'd0);
    send(1'b0, 8'h19, 2'd1);
    send(1'b0, 8'h05, 2'd2);
    send(1'b0, 8'hFF, 2'd0);
    drain();
    check("b2b_count", hs_log_cyc.size(), 32'd4);
    if (hs_log_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("b2b_spacing", hs_log_cyc[i] - hs_log_cyc[i-1], WIDTH + 2);
    end

    // reset mid-shift: no result, outputs cleared, tie restarts with req0
    req0_data = 8'h93; req0_valid = 1'b1;
    wait_hs(1'b0, ok);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_outputs("abort");
    hs_log_cyc.delete(); hs_log_id.delete();
    fork
      send(1'b0, 8'h03, 2'd0);
      send(1'b1, 8'h04, 2'd1);
    join
    drain();
    check("tie_after_reset_count", hs_log_id.size(), 32'd2);
    if (hs_log_id.size() == 2)
      check("tie_after_reset_first", {31'd0, hs_log_id[0]}, 32'd0);
    send(1'b1, 8'h19, 2'd1);
    drain();

    // exhaustive through req0
    for (int v = 0; v < 256; v++)
      send(1'b0, v[WIDTH-1:0], 2'(v % 3));
    drain();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
